// File: rtl/ibex_rf_wport_arbiter.sv
// ibex_rf_wport_arbiter: shares the integer register-file write port between
// the unstallable core writeback path and buffered FPU integer results.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   core_we_i/waddr_i/wdata_i     core writeback request (always granted)
//   fpu_valid_i/ready_o           FPU result handshake
//   fpu_waddr_i/wdata_i           FPU destination register and data
//   flush_i                       drop all buffered FPU results
//   hazard_raddr_a_i/b_i          ID operand addresses for the hazard check
//   hazard_o                      operand matches a pending FPU write
//   stall_core_o                  ask ID/EX to withhold core writes
//   rf_we_o/waddr_o/wdata_o       register file write port
//   fifo_empty_o                  no buffered FPU results
module ibex_rf_wport_arbiter #(
  parameter int unsigned FifoDepth   = 2,
  parameter int unsigned StarveLimit = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_we_i,
  input  logic [4:0]  core_waddr_i,
  input  logic [31:0] core_wdata_i,
  input  logic        fpu_valid_i,
  output logic        fpu_ready_o,
  input  logic [4:0]  fpu_waddr_i,
  input  logic [31:0] fpu_wdata_i,
  input  logic        flush_i,
  input  logic [4:0]  hazard_raddr_a_i,
  input  logic [4:0]  hazard_raddr_b_i,
  output logic        hazard_o,
  output logic        stall_core_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        fifo_empty_o
);

  localparam int unsigned PtrW =
    (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(FifoDepth);
  localparam logic [3:0] LimitC = 4'(StarveLimit);

  // FIFO storage; r_wr marks entries that really write (non-x0)
  logic [4:0]           r_addr [FifoDepth];
  logic [31:0]          r_data [FifoDepth];
  logic [FifoDepth-1:0] r_vld;
  logic [FifoDepth-1:0] r_wr;
  logic [PtrW-1:0]      r_wptr;
  logic [PtrW-1:0]      r_rptr;
  logic [CntW-1:0]      r_count;
  logic [3:0]           r_wait;
  logic                 r_stall;

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_head_wr;
  logic [4:0]  w_head_addr;
  logic [31:0] w_head_data;
  logic [3:0]  w_wait_nxt;
  logic        w_hazard;
  logic        w_a_nz;
  logic        w_b_nz;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DepthC);

  // Ready comes only from registered state, never from a pop this cycle
  assign fpu_ready_o = ~w_full & ~flush_i;
  assign w_push      = fpu_valid_i & fpu_ready_o;

  // The core always wins the port; reset suppresses any drain
  assign w_pop = ~rst_i & ~core_we_i & ~w_empty;

  assign w_head_wr   = r_wr[r_rptr];
  assign w_head_addr = r_addr[r_rptr];
  assign w_head_data = r_data[r_rptr];

  assign rf_we_o    = core_we_i | (w_pop & w_head_wr);
  assign rf_waddr_o = core_we_i ? core_waddr_i : w_head_addr;
  assign rf_wdata_o = core_we_i ? core_wdata_i : w_head_data;

  assign fifo_empty_o = w_empty;
  assign stall_core_o = r_stall;

  always_comb begin
    w_wait_nxt = r_wait;
    if (w_pop || w_empty) begin
      w_wait_nxt = '0;
    end else if (core_we_i && (r_wait != LimitC)) begin
      w_wait_nxt = r_wait + 4'd1;
    end
  end

  assign w_a_nz = (hazard_raddr_a_i != 5'd0);
  assign w_b_nz = (hazard_raddr_b_i != 5'd0);

  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < int'(FifoDepth); i++) begin
      if (r_vld[i] && r_wr[i]) begin
        if ((w_a_nz && (r_addr[i] == hazard_raddr_a_i)) ||
            (w_b_nz && (r_addr[i] == hazard_raddr_b_i))) begin
          w_hazard = 1'b1;
        end
      end
    end
  end

  assign hazard_o = w_hazard;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_addr[r_wptr] <= fpu_waddr_i;
      r_data[r_wptr] <= fpu_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld   <= '0;
      r_wr    <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_wait  <= '0;
      r_stall <= 1'b0;
    end else if (flush_i) begin
      r_vld   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_wait  <= '0;
      r_stall <= 1'b0;
    end else begin
      if (w_push) begin
        r_vld[r_wptr] <= 1'b1;
        r_wr[r_wptr]  <= (fpu_waddr_i != 5'd0);
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_wait  <= w_wait_nxt;
      r_stall <= (w_wait_nxt == LimitC);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (r_count <= DepthC);
      assert (!(w_pop && w_empty));
      assert (!rf_we_o ||
              $onehot({core_we_i, w_pop & w_head_wr}));
      assert (!(r_stall && core_we_i));
    end
  end

endmodule

// File: tb/tb_ibex_rf_wport_arbiter.sv
// Directed self-checking bench for ibex_rf_wport_arbiter.
// Linear stimulus with hand-computed expectations.
module tb_ibex_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_we;
  logic [4:0]  core_waddr;
  logic [31:0] core_wdata;
  logic        fpu_valid;
  logic        fpu_ready;
  logic [4:0]  fpu_waddr;
  logic [31:0] fpu_wdata;
  logic        flush;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        hazard;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fempty;

  int checks = 0;
  int errors = 0;

  ibex_rf_wport_arbiter #(
    .FifoDepth(2),
    .StarveLimit(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .core_we_i(core_we),
    .core_waddr_i(core_waddr),
    .core_wdata_i(core_wdata),
    .fpu_valid_i(fpu_valid),
    .fpu_ready_o(fpu_ready),
    .fpu_waddr_i(fpu_waddr),
    .fpu_wdata_i(fpu_wdata),
    .flush_i(flush),
    .hazard_raddr_a_i(ra),
    .hazard_raddr_b_i(rb),
    .hazard_o(hazard),
    .stall_core_o(stall),
    .rf_we_o(rf_we),
    .rf_waddr_o(rf_waddr),
    .rf_wdata_o(rf_wdata),
    .fifo_empty_o(fempty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fpu(input logic v, input logic [4:0] a,
                     input logic [31:0] d);
    fpu_valid = v;
    fpu_waddr = a;
    fpu_wdata = d;
  endtask

  initial begin
    rst = 1'b1;
    core_we = 1'b0;
    core_waddr = 5'd0;
    core_wdata = 32'd0;
    fpu(1'b0, 5'd0, 32'd0);
    flush = 1'b0;
    ra = 5'd0;
    rb = 5'd0;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_ready", fpu_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_empty", fempty, 1);
    chk("rst_we", rf_we, 0);
    core_we = 1'b1;
    settle();
    chk("core_follow", rf_we, 1);
    core_we = 1'b0;

    // single FPU result, core idle, one cycle latency
    fpu(1'b1, 5'd5, 32'h3F800000);
    settle();
    chk("t1_nobypass", rf_we, 0);
    tick();
    fpu(1'b0, 5'd0, 32'd0);
    settle();
    chk("t1_we", rf_we, 1);
    chk("t1_addr", rf_waddr, 5);
    chk("t1_data", rf_wdata, 32'h3F800000);
    tick();
    settle();
    chk("t1_empty", fempty, 1);
    chk("t1_we_after", rf_we, 0);

    // core hogs the port until starvation stall
    core_we = 1'b1;
    core_waddr = 5'd7;
    core_wdata = 32'h11111111;
    fpu(1'b1, 5'd10, 32'hAAAA0001);
    settle();
    chk("t2_core_addr", rf_waddr, 7);
    tick();
    fpu(1'b1, 5'd11, 32'hBBBB0002);
    settle();
    chk("t2_ready1", fpu_ready, 1);
    tick();
    fpu(1'b0, 5'd0, 32'd0);
    settle();
    chk("t2_full_ready", fpu_ready, 0);
    chk("t2_core_we", rf_we, 1);
    chk("t2_core_data", rf_wdata, 32'h11111111);
    chk("t2_stall_w1", stall, 0);
    tick();
    tick();
    settle();
    chk("t2_stall_w3", stall, 0);
    tick();
    core_we = 1'b0;
    settle();
    chk("t2_stall", stall, 1);
    chk("t2_pop1_we", rf_we, 1);
    chk("t2_pop1_addr", rf_waddr, 10);
    chk("t2_pop1_data", rf_wdata, 32'hAAAA0001);
    tick();
    settle();
    chk("t2_stall_clr", stall, 0);
    chk("t2_pop2_addr", rf_waddr, 11);
    chk("t2_pop2_data", rf_wdata, 32'hBBBB0002);
    chk("t2_ready2", fpu_ready, 1);
    tick();
    settle();
    chk("t2_empty", fempty, 1);
    chk("t2_idle_we", rf_we, 0);

    // hazard on x9, x0 entry never raises hazard
    core_we = 1'b1;
    fpu(1'b1, 5'd9, 32'h00000C0C);
    tick();
    fpu(1'b1, 5'd0, 32'h00000D0D);
    tick();
    fpu(1'b0, 5'd0, 32'd0);
    rb = 5'd9;
    settle();
    chk("t3_haz_b9", hazard, 1);
    tick();
    settle();
    chk("t3_haz_hold", hazard, 1);
    rb = 5'd0;
    ra = 5'd0;
    settle();
    chk("t3_haz_x0", hazard, 0);
    rb = 5'd9;
    core_we = 1'b0;
    settle();
    chk("t3_pop_addr", rf_waddr, 9);
    chk("t3_haz_pop", hazard, 1);
    tick();
    settle();
    chk("t3_haz_gone", hazard, 0);
    chk("t3_x0_nowe", rf_we, 0);
    chk("t3_x0_pend", fempty, 0);
    tick();
    settle();
    chk("t3_empty", fempty, 1);
    rb = 5'd0;

    // lone x0 result with idle core
    fpu(1'b1, 5'd0, 32'h12345678);
    tick();
    fpu(1'b0, 5'd0, 32'd0);
    settle();
    chk("t4_x0_we", rf_we, 0);
    chk("t4_x0_cnt", fempty, 0);
    tick();
    settle();
    chk("t4_x0_empty", fempty, 1);

    // streaming push and pop in the same cycle
    fpu(1'b1, 5'd20, 32'd1);
    tick();
    fpu(1'b1, 5'd20, 32'd2);
    settle();
    chk("t5_s1_data", rf_wdata, 1);
    chk("t5_s1_ready", fpu_ready, 1);
    tick();
    fpu(1'b1, 5'd20, 32'd3);
    settle();
    chk("t5_s2_data", rf_wdata, 2);
    tick();
    fpu(1'b0, 5'd0, 32'd0);
    settle();
    chk("t5_s3_data", rf_wdata, 3);
    chk("t5_s3_we", rf_we, 1);
    tick();
    settle();
    chk("t5_empty", fempty, 1);

    // flush discards buffered entries and the concurrent offer
    core_we = 1'b1;
    fpu(1'b1, 5'd12, 32'hC);
    tick();
    fpu(1'b1, 5'd13, 32'hD);
    tick();
    flush = 1'b1;
    fpu(1'b1, 5'd14, 32'hE);
    settle();
    chk("t6_flush_ready", fpu_ready, 0);
    tick();
    flush = 1'b0;
    fpu(1'b0, 5'd0, 32'd0);
    core_we = 1'b0;
    settle();
    chk("t6_empty", fempty, 1);
    chk("t6_nowe", rf_we, 0);
    chk("t6_ready", fpu_ready, 1);
    chk("t6_stall", stall, 0);
    tick();
    settle();
    chk("t6_nowe2", rf_we, 0);

    // reset with a full FIFO and stall raised
    core_we = 1'b1;
    fpu(1'b1, 5'd15, 32'hF);
    tick();
    fpu(1'b1, 5'd16, 32'h10);
    tick();
    fpu(1'b0, 5'd0, 32'd0);
    tick();
    tick();
    tick();
    core_we = 1'b0;
    rst = 1'b1;
    settle();
    chk("t7_pre_stall", stall, 1);
    chk("t7_pre_ready", fpu_ready, 0);
    chk("t7_rst_nowe", rf_we, 0);
    tick();
    rst = 1'b0;
    settle();
    chk("t7_stall", stall, 0);
    chk("t7_ready", fpu_ready, 1);
    chk("t7_empty", fempty, 1);
    chk("t7_nowe", rf_we, 0);
    tick();
    settle();
    chk("t7_nowe2", rf_we, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ibex_rf_wport_arbiter.md
Name: ibex_rf_wport_arbiter

Overview:
- Shares the single integer register-file write port between two sources:
  - the core writeback path (ID/EX results and LSU load data, already merged; cannot be stalled);
  - the floating-point unit's integer-destination results (fcvt.w.s, feq/flt/fle, fclass, fmv.x.w), which use a valid/ready handshake.
- FPU results are buffered in a small FIFO and drained into idle port cycles.
- A starvation counter requests an ID/EX stall so the FIFO head is guaranteed a slot.
- A read-hazard check lets ID/EX stall on operands still sitting in the FIFO.
- Sits between the writeback stage outputs and the register file write port.

Parameters:
- FifoDepth, 2, number of buffered FPU results (power of two, 2..8).
- StarveLimit, 4, consecutive blocked cycles of the FIFO head before a core stall is requested (1..15).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- core_we_i  in  1  core write request; always granted
- core_waddr_i  in  5  core write address
- core_wdata_i  in  32  core write data
- fpu_valid_i  in  1  FPU result valid
- fpu_ready_o  out  1  arbiter can accept an FPU result
- fpu_waddr_i  in  5  FPU destination register
- fpu_wdata_i  in  32  FPU result data
- flush_i  in  1  discard all buffered FPU results (exception/kill)
- hazard_raddr_a_i  in  5  ID operand A address
- hazard_raddr_b_i  in  5  ID operand B address
- hazard_o  out  1  operand matches a pending FPU write
- stall_core_o  out  1  request ID/EX to withhold core writes next cycle
- rf_we_o  out  1  register file write enable
- rf_waddr_o  out  5  register file write address
- rf_wdata_o  out  32  register file write data
- fifo_empty_o  out  1  no buffered FPU results

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - FIFO emptied, pointers and occupancy count cleared, wait counter cleared.
  - After reset: fpu_ready_o=1, stall_core_o=0, hazard_o=0, fifo_empty_o=1.
  - rf_we_o follows core_we_i combinationally; no FPU write occurs.
  - Reset mid-operation drops all buffered results; no partial write.
- Accept:
  - An FPU handshake occurs when fpu_valid_i & fpu_ready_o & ~flush_i.
  - fpu_ready_o = (count != FifoDepth) & ~flush_i; driven from registered count only.
  - When full, fpu_ready_o stays 0 even in a pop cycle (no ready-through-pop path).
- Results to x0: accepted, but written into the FIFO marked non-writing. On drain they pop without asserting rf_we_o and never raise hazard_o.
- Port arbitration, each cycle:
  - core_we_i=1: rf_* = core inputs; FIFO does not pop.
  - core_we_i=0 and FIFO non-empty: head popped; rf_we_o = head writing flag; rf_waddr_o/rf_wdata_o = head.
  - core_we_i=0 and FIFO empty: rf_we_o=0.
  - There is no same-cycle bypass. An accepted result is written no earlier than the next cycle, so minimum latency is 1 cycle.
  - rf_we_o never combines two sources. The core always wins.
- Simultaneous push and pop: allowed when count < FifoDepth; count unchanged. Pointers wrap modulo FifoDepth.
- Starvation:
  - wait_cnt (4 bits) increments each cycle the FIFO is non-empty and core_we_i=1.
  - It clears on any pop, on flush, and when the FIFO is empty.
  - It saturates at StarveLimit.
  - stall_core_o = (wait_cnt == StarveLimit), registered.
  - ID/EX must hold core_we_i=0 in the cycle after stall_core_o rises; the head then drains and wait_cnt clears.
  - If core_we_i=1 is nevertheless seen while stall_core_o=1, the core still wins. An assertion flags this protocol violation.
- Hazard: hazard_o=1 if any valid, writing FIFO entry has waddr equal to a non-zero hazard_raddr_a_i or hazard_raddr_b_i. The check is combinational over valid entries only.
- Flush:
  - Takes effect at the clock edge: count=0, pointers=0, wait_cnt=0.
  - Any FPU offer in the flush cycle is not accepted.
  - A pop coinciding with flush still performs its write (the head was committed).
- Ordering: FPU results are written in acceptance order. Multiple entries to the same register resolve to the last accepted.
- Assertions:
  - count never exceeds FifoDepth.
  - No pop when empty.
  - rf_we_o implies exactly one source selected.

Test Plan:
- Reset, then fpu_valid_i=1 with waddr=5, wdata=0x3F800000, core idle → accepted cycle 0; cycle 1: rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x3F800000; fifo_empty_o=1 after.
- core_we_i held 1 (waddr=7) while two FPU results arrive (FifoDepth=2) → fpu_ready_o=0 after the second; core writes every cycle; stall_core_o=1 after 4 blocked cycles. Then core_we_i=0 for two cycles → both FPU results written in order; wait_cnt=0; stall_core_o=0.
- FPU writes x9 buffered behind core writes; hazard_raddr_b_i=9 → hazard_o=1 until the x9 entry drains. hazard_raddr_a_i=0 with a pending x0 entry → hazard_o=0.
- FPU result to x0, core idle → popped with rf_we_o=0; count returns to 0.
- Two entries buffered, flush_i=1 while fpu_valid_i=1 → no accept; next cycle fifo_empty_o=1, no FPU write ever occurs.
- rst_i asserted with a full FIFO and stall_core_o=1 → next cycle stall_core_o=0, fpu_ready_o=1, fifo_empty_o=1, no spurious rf_we_o.
